// File: rtl/eeprom_rw_test.sv
// EEPROM write/read-back sequencer: writes k^PATTERN to a contiguous address range,
// reads it back through the I2C EEPROM driver's byte handshake, and reports the outcome.
module eeprom_rw_test #(
  parameter int unsigned NUM_BYTES  = 256,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter logic [7:0]  PATTERN    = 8'h00,
  parameter logic        BIT_CTRL   = 1'b1,
  parameter logic [15:0] WR_GAP     = 16'd5000,
  parameter logic [15:0] TIMEOUT    = 16'd60000,
  parameter logic [23:0] LED_HALF   = 24'd250000,
  parameter logic        AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        i2c_exec,
  output logic        bit_ctrl,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        rw_done,
  output logic        rw_pass,
  output logic [1:0]  err_code,
  output logic [15:0] err_addr,
  output logic        led,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_GAP   = 3'd3;
  localparam logic [2:0] S_RD_ISSUE = 3'd4;
  localparam logic [2:0] S_RD_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_FAIL     = 3'd7;

  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_DATA = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [8:0] LAST_K = 9'(NUM_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [8:0]  k_q, k_d;
  logic [15:0] cnt_q, cnt_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] eaddr_q, eaddr_d;
  logic        led_q, led_d;
  logic [23:0] led_cnt_q, led_cnt_d;
  logic        rh_q, rh_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        begin_run, fail_go, wr_next;
  logic [1:0]  fail_code;
  logic        gap_end, tmo_hit, blink_end;
  logic [7:0]  exp_byte;

  // Handshake: i2c_exec is a one-cycle command strobe while rh_wl/addr/data_w are stable;
  // the driver answers with a one-cycle i2c_done, and i2c_ack/i2c_data_r are sampled only
  // with that pulse in a WAIT state. Any other i2c_done is ignored.
  assign i2c_exec   = (state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE);
  assign bit_ctrl   = BIT_CTRL;
  assign i2c_rh_wl  = rh_q;
  assign i2c_addr   = addr_q;
  assign i2c_data_w = data_q;
  assign rw_done    = done_q;
  assign rw_pass    = pass_q;
  assign err_code   = code_q;
  assign err_addr   = eaddr_q;
  assign led        = led_q;
  assign dbg_state  = state_q;

  // cnt_q is 1 in the first WAIT cycle, so it equals cycles elapsed since i2c_exec.
  assign gap_end   = ({1'b0, cnt_q} + 17'd1) >= {1'b0, WR_GAP};
  assign tmo_hit   = ({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT};
  assign blink_end = ({1'b0, led_cnt_q} + 25'd1) >= {1'b0, LED_HALF};
  assign exp_byte  = k_q[7:0] ^ PATTERN;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    auto_d    = auto_q;
    done_d    = done_q;
    pass_d    = pass_q;
    code_d    = code_q;
    eaddr_d   = eaddr_q;
    led_d     = led_q;
    led_cnt_d = led_cnt_q;
    rh_d      = rh_q;
    addr_d    = addr_q;
    data_d    = data_q;
    begin_run = 1'b0;
    fail_go   = 1'b0;
    fail_code = 2'd0;
    wr_next   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin_run = 1'b1;
      end
      S_WR_ISSUE: begin
        state_d = S_WR_WAIT;
        cnt_d   = 16'd1;
      end
      S_WR_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            fail_go   = 1'b1;
            fail_code = ERR_NACK;
          end else if (WR_GAP == 16'd0) begin
            wr_next = 1'b1;
          end else begin
            state_d = S_WR_GAP;
            cnt_d   = 16'd0;
          end
        end else if (tmo_hit) begin
          fail_go   = 1'b1;
          fail_code = ERR_TMO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WR_GAP: begin
        if (gap_end) wr_next = 1'b1;
        else         cnt_d   = cnt_q + 16'd1;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = 16'd1;
      end
      S_RD_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            fail_go   = 1'b1;
            fail_code = ERR_NACK;
          end else if (i2c_data_r != exp_byte) begin
            fail_go   = 1'b1;
            fail_code = ERR_DATA;
          end else if (k_q == LAST_K) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            led_d   = 1'b1;
          end else begin
            k_d     = k_q + 9'd1;
            state_d = S_RD_ISSUE;
          end
        end else if (tmo_hit) begin
          fail_go   = 1'b1;
          fail_code = ERR_TMO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (start) begin_run = 1'b1;
      end
      S_FAIL: begin
        if (start) begin
          begin_run = 1'b1;
        end else if (blink_end) begin
          led_d     = ~led_q;
          led_cnt_d = 24'd0;
        end else begin
          led_cnt_d = led_cnt_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_next) begin
      if (k_q < LAST_K) begin
        k_d     = k_q + 9'd1;
        state_d = S_WR_ISSUE;
      end else begin
        k_d     = 9'd0;
        state_d = S_RD_ISSUE;
      end
    end

    // The failing transaction's address is still held on i2c_addr.
    if (fail_go) begin
      state_d   = S_FAIL;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      code_d    = fail_code;
      eaddr_d   = addr_q;
      led_d     = 1'b0;
      led_cnt_d = 24'd0;
    end

    if (begin_run) begin
      state_d   = S_WR_ISSUE;
      k_d       = 9'd0;
      auto_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      code_d    = 2'd0;
      eaddr_d   = 16'd0;
      led_d     = 1'b0;
      led_cnt_d = 24'd0;
    end

    // Command fields are loaded on entry to ISSUE and held until the next ISSUE.
    if (state_d == S_WR_ISSUE) begin
      rh_d   = 1'b0;
      addr_d = BASE_ADDR + {7'd0, k_d};
      data_d = k_d[7:0] ^ PATTERN;
    end else if (state_d == S_RD_ISSUE) begin
      rh_d   = 1'b1;
      addr_d = BASE_ADDR + {7'd0, k_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= 9'd0;
      cnt_q     <= 16'd0;
      auto_q    <= AUTO_START;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      code_q    <= 2'd0;
      eaddr_q   <= 16'd0;
      led_q     <= 1'b0;
      led_cnt_q <= 24'd0;
      rh_q      <= 1'b0;
      addr_q    <= 16'd0;
      data_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      auto_q    <= auto_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      code_q    <= code_d;
      eaddr_q   <= eaddr_d;
      led_q     <= led_d;
      led_cnt_q <= led_cnt_d;
      rh_q      <= rh_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_eeprom_rw_test.sv
// Bench for eeprom_rw_test: a driver/EEPROM model answers each command and checks it
// against an expected-command queue; directed steps cover pass, NACK, mismatch, timeout, reset.
module tb_eeprom_rw_test;

  localparam int          NB   = 4;
  localparam logic [15:0] BASE = 16'hFFFE;
  localparam logic [7:0]  PAT  = 8'h00;
  localparam int          GAP  = 10;
  localparam int          TMO  = 100;
  localparam int          LEDH = 8;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        i2c_exec, bit_ctrl, i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;
  logic        i2c_done, i2c_ack;
  logic        rw_done, rw_pass, led;
  logic [1:0]  err_code;
  logic [15:0] err_addr;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eeprom_rw_test #(
    .NUM_BYTES(NB), .BASE_ADDR(BASE), .PATTERN(PAT), .BIT_CTRL(1'b1),
    .WR_GAP(16'(GAP)), .TIMEOUT(16'(TMO)), .LED_HALF(24'(LEDH)), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .i2c_exec(i2c_exec), .bit_ctrl(bit_ctrl), .i2c_rh_wl(i2c_rh_wl),
    .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .rw_done(rw_done), .rw_pass(rw_pass), .err_code(err_code),
    .err_addr(err_addr), .led(led), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // Expected commands: {rh_wl, addr, data_w}; data_w is don't-care (0) for reads.
  logic [24:0] exp_q[$];

  int lat = 1;
  int nack_wr_k = -1;
  int bad_rd_k = -1;
  bit hang = 1'b0;
  int n_exec = 0;
  int last_exec_cyc = 0;
  int prev_cyc = 0;
  bit prev_valid = 1'b0;
  bit prev_rd = 1'b0;
  logic [7:0] mem [logic [15:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_run(input int nw, input int nr);
    logic [15:0] kk;
    for (int k = 0; k < nw; k++) begin
      kk = 16'(k);
      exp_q.push_back({1'b0, 16'(BASE + kk), kk[7:0] ^ PAT});
    end
    for (int k = 0; k < nr; k++) begin
      kk = 16'(k);
      exp_q.push_back({1'b1, 16'(BASE + kk), 8'h00});
    end
  endtask

  // Driver/EEPROM model: serves one command, entered at the negedge where i2c_exec is seen.
  task automatic serve();
    logic        rh;
    logic [15:0] a;
    logic [7:0]  d;
    logic [24:0] obs;
    int          k;
    rh  = i2c_rh_wl;
    a   = i2c_addr;
    d   = i2c_data_w;
    k   = int'(16'(a - BASE));
    obs = {rh, a, rh ? 8'h00 : d};
    n_exec++;
    check("exec_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) check("exec_cmd", 32'(obs), 32'(exp_q.pop_front()));
    if (prev_valid) check("exec_spacing", 32'(cyc - prev_cyc), 32'(prev_rd ? lat + 1 : lat + GAP + 1));
    prev_cyc      = cyc;
    prev_rd       = rh;
    prev_valid    = 1'b1;
    last_exec_cyc = cyc;
    @(negedge clk);
    check("exec_one_cycle", 32'(i2c_exec), 32'd0);
    if (!hang) begin
      repeat (lat - 1) @(negedge clk);
      i2c_done = 1'b1;
      if (!rh) begin
        mem[a]     = d;
        i2c_ack    = (k == nack_wr_k);
        i2c_data_r = 8'h00;
      end else begin
        i2c_ack    = 1'b0;
        i2c_data_r = (k == bad_rd_k) ? 8'hFF : mem[a];
      end
      @(negedge clk);
      i2c_done   = 1'b0;
      i2c_ack    = 1'b0;
      i2c_data_r = 8'h00;
    end
  endtask

  initial begin
    i2c_done   = 1'b0;
    i2c_ack    = 1'b0;
    i2c_data_r = 8'h00;
    @(negedge clk);
    forever begin
      if (rst_n === 1'b1 && i2c_exec === 1'b1) serve();
      else @(negedge clk);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_exec"},     32'(i2c_exec),   32'd0);
    check({tag, "_rh_wl"},    32'(i2c_rh_wl),  32'd0);
    check({tag, "_addr"},     32'(i2c_addr),   32'd0);
    check({tag, "_data_w"},   32'(i2c_data_w), 32'd0);
    check({tag, "_rw_done"},  32'(rw_done),    32'd0);
    check({tag, "_rw_pass"},  32'(rw_pass),    32'd0);
    check({tag, "_err_code"}, 32'(err_code),   32'd0);
    check({tag, "_err_addr"}, 32'(err_addr),   32'd0);
    check({tag, "_led"},      32'(led),        32'd0);
    check({tag, "_bit_ctrl"}, 32'(bit_ctrl),   32'd1);
    check({tag, "_state"},    32'(dbg_state),  32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (rw_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'(rw_done), 32'd1);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr_done"}, 32'(rw_done),  32'd0);
    check({tag, "_clr_code"}, 32'(err_code), 32'd0);
    check({tag, "_clr_led"},  32'(led),      32'd0);
  endtask

  task automatic wait_led_change(output int n);
    logic l0;
    l0 = led;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led === l0 && n < 4 * LEDH);
  endtask

  initial begin
    int n1, n2, n3, n0, t0, w;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Auto-started pass run across the 16-bit address wrap.
    lat = 1;
    prev_valid = 1'b0;
    push_run(NB, NB);
    rst_n = 1'b1;
    wait_done("pass");
    check("pass_rw_pass",  32'(rw_pass),      32'd1);
    check("pass_err_code", 32'(err_code),     32'd0);
    check("pass_led",      32'(led),          32'd1);
    check("pass_queue",    32'(exp_q.size()), 32'd0);

    // Restart from DONE, write NACK at k=1.
    nack_wr_k = 1;
    lat = 2;
    prev_valid = 1'b0;
    push_run(2, 0);
    pulse_start("nack");
    wait_done("nack");
    check("nack_err_code", 32'(err_code),     32'd1);
    check("nack_err_addr", 32'(err_addr),     32'hFFFF);
    check("nack_rw_pass",  32'(rw_pass),      32'd0);
    check("nack_queue",    32'(exp_q.size()), 32'd0);
    n0 = n_exec;
    wait_led_change(n1);
    wait_led_change(n2);
    wait_led_change(n3);
    check("nack_led_first", 32'(n1 < 4 * LEDH), 32'd1);
    check("nack_led_half1", 32'(n2), 32'(LEDH));
    check("nack_led_half2", 32'(n3), 32'(LEDH));
    check("nack_no_exec",   32'(n_exec), 32'(n0));
    nack_wr_k = -1;

    // Read mismatch at k=3 with a random driver latency.
    bad_rd_k = 3;
    lat = $urandom_range(1, 4);
    prev_valid = 1'b0;
    push_run(NB, NB);
    pulse_start("mism");
    wait_done("mism");
    check("mism_err_code", 32'(err_code),     32'd2);
    check("mism_err_addr", 32'(err_addr),     32'h0001);
    check("mism_rw_pass",  32'(rw_pass),      32'd0);
    check("mism_queue",    32'(exp_q.size()), 32'd0);
    bad_rd_k = -1;

    // Timeout: driver never answers the first write.
    hang = 1'b1;
    prev_valid = 1'b0;
    push_run(1, 0);
    pulse_start("tmo");
    wait_done("tmo");
    check("tmo_err_code", 32'(err_code), 32'd3);
    check("tmo_err_addr", 32'(err_addr), 32'(BASE));
    check("tmo_latency",  32'(cyc - last_exec_cyc), 32'(TMO));

    // Reset while waiting on the first write, then auto-restart from k=0.
    prev_valid = 1'b0;
    push_run(1, 0);
    t0 = n_exec;
    pulse_start("rst");
    w = 0;
    while (n_exec == t0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_exec_seen", 32'(n_exec > t0), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    hang = 1'b0;
    repeat (3) @(negedge clk);
    lat = 1;
    prev_valid = 1'b0;
    push_run(NB, NB);
    rst_n = 1'b1;
    wait_done("rerun");
    check("rerun_rw_pass",  32'(rw_pass),      32'd1);
    check("rerun_err_code", 32'(err_code),     32'd0);
    check("rerun_led",      32'(led),          32'd1);
    check("rerun_queue",    32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
